// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - 5-bit SAR ADC controller: tick divider, sample/hold/trial sequencing, result register.
// Optional CLOCK_TEST_EN macro drives the divided tick clock onto clock_test; otherwise it is tied low.
module sar_adc_ctrl #(
    parameter int CLK_DIV      = 10,
    parameter int SAMPLE_TICKS = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       analog_cmp_p,
    input  logic       analog_cmp_n,
    output logic [5:0] c,
    output logic       c_gnd,
    output logic       sample_switch,
    output logic [4:0] n,
    output logic       clock_test
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int SW = $clog2(SAMPLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_TICKS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
    localparam logic [2:0] S_TRIAL  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    state_q, state_d;
    logic [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [4:0]    trial_q, trial_d;
    logic [5:0]    c_q, c_d;
    logic          c_gnd_q, c_gnd_d;
    logic          ss_q, ss_d;
    logic [4:0]    n_q, n_d;
    logic          sync1_q, cmp_s_q;
    logic          cmp_raw;
    logic          tick;
    logic [5:0]    trial_mask;
    logic [5:0]    c_kept;

    // An invalid comparator pair (both rails equal) resolves as a reject.
    assign cmp_raw = analog_cmp_p & ~analog_cmp_n;
    assign tick    = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        bit_d      = bit_q;
        trial_d    = trial_q;
        c_d        = c_q;
        c_gnd_d    = c_gnd_q;
        ss_d       = ss_q;
        n_d        = n_q;
        trial_mask = 6'b000010 << bit_q;
        c_kept     = c_q;
        if (tick) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d    = S_SAMPLE;
                    samp_cnt_d = '0;
                    ss_d       = 1'b1;
                    c_gnd_d    = 1'b1;
                    c_d        = '0;
                end
                S_SAMPLE: begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        state_d = S_HOLD;
                        ss_d    = 1'b0;
                        c_gnd_d = 1'b0;
                    end else begin
                        samp_cnt_d = samp_cnt_q + SW'(1);
                    end
                end
                S_HOLD: begin
                    state_d = S_TRIAL;
                    bit_d   = 3'd4;
                    trial_d = '0;
                    c_d     = 6'b100000;
                end
                S_TRIAL: begin
                    // Resolve the current bit, then raise the next lower trial bit on the same edge.
                    trial_d = trial_q | (5'(cmp_s_q) << bit_q);
                    c_kept  = cmp_s_q ? c_q : (c_q & ~trial_mask);
                    if (bit_q == 3'd0) begin
                        state_d = S_DONE;
                        n_d     = trial_d;
                        c_d     = '0;
                        c_gnd_d = 1'b1;
                    end else begin
                        bit_d = bit_q - 3'd1;
                        c_d   = c_kept | (trial_mask >> 1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    c_d     = '0;
                    c_gnd_d = 1'b1;
                    ss_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            samp_cnt_q <= '0;
            bit_q      <= '0;
            trial_q    <= '0;
            c_q        <= '0;
            c_gnd_q    <= 1'b1;
            ss_q       <= 1'b0;
            n_q        <= '0;
            sync1_q    <= 1'b0;
            cmp_s_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            bit_q      <= bit_d;
            trial_q    <= trial_d;
            c_q        <= c_d;
            c_gnd_q    <= c_gnd_d;
            ss_q       <= ss_d;
            n_q        <= n_d;
            sync1_q    <= cmp_raw;
            cmp_s_q    <= sync1_q;
        end
    end

`ifdef CLOCK_TEST_EN
    logic clk_test_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            clk_test_q <= 1'b0;
        end else begin
            clk_test_q <= (cnt_d < CNT_HALF);
        end
    end

    assign clock_test = clk_test_q;
`else
    assign clock_test = 1'b0;
`endif

    assign c             = c_q;
    assign c_gnd         = c_gnd_q;
    assign sample_switch = ss_q;
    assign n             = n_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - self-checking bench for sar_adc_ctrl against a tick-phase reference model.
module tb_sar_adc_ctrl;

    logic       clk_in;
    logic       rst_in;
    logic       cmp_p;
    logic       cmp_n;
    logic [5:0] c;
    logic       c_gnd;
    logic       sample_switch;
    logic [4:0] n;
    logic       clock_test;

    int errors;
    int checks;
    int mode;
    int vin10;

    sar_adc_ctrl #(.CLK_DIV(10), .SAMPLE_TICKS(4)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .analog_cmp_p (cmp_p),
        .analog_cmp_n (cmp_n),
        .c            (c),
        .c_gnd        (c_gnd),
        .sample_switch(sample_switch),
        .n            (n),
        .clock_test   (clock_test)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Comparator model: 0 reject, 1 accept, 2 keep iff DAC code <= vin, 3 invalid pair.
    always_comb begin
        cmp_p = 1'b0;
        cmp_n = 1'b1;
        case (mode)
            1: begin cmp_p = 1'b1; cmp_n = 1'b0; end
            2: begin
                cmp_p = (int'(c[5:1]) * 10 <= vin10);
                cmp_n = ~cmp_p;
            end
            3: begin cmp_p = 1'b1; cmp_n = 1'b1; end
            default: begin cmp_p = 1'b0; cmp_n = 1'b1; end
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (cycles) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // Called right after release; checks tick intervals 0..last_j mid-interval.
    task automatic run_conv(input string name, input int nexp, input int last_j);
        int e;
        int q;
        int k;
        logic [5:0] ec;
        logic       eg;
        logic       es;
        logic [4:0] en;
        logic [4:0] code;
        e = 0;
        for (int j = 0; j <= last_j; j++) begin
            while (e < 10 * j + 5) begin
                @(posedge clk_in);
                e++;
            end
            #1;
            ec = 6'd0;
            eg = 1'b1;
            es = 1'b0;
            if (j >= 1) begin
                q = (j - 1) % 11;
                if (q <= 3) begin
                    es = 1'b1;
                end else if (q == 4) begin
                    eg = 1'b0;
                end else if (q <= 9) begin
                    k    = 9 - q;
                    code = 5'(((nexp >> (k + 1)) << (k + 1)) | (1 << k));
                    ec   = {code, 1'b0};
                    eg   = 1'b0;
                end
            end
            en = (j >= 11) ? 5'(nexp) : 5'd0;
            chk($sformatf("%s_c_j%0d", name, j), {2'b0, c}, {2'b0, ec});
            chk($sformatf("%s_gnd_j%0d", name, j), {7'b0, c_gnd}, {7'b0, eg});
            chk($sformatf("%s_ss_j%0d", name, j), {7'b0, sample_switch}, {7'b0, es});
            chk($sformatf("%s_n_j%0d", name, j), {3'b0, n}, {3'b0, en});
        end
    endtask

    initial begin
        logic [9:0] rs;
        int nexp;
        int highs;
        int diffs;
        int rises;
        logic ct [0:29];
        errors = 0;
        checks = 0;
        mode   = 0;
        vin10  = 0;
        rst_in = 1'b1;

        // Long reset hold, sampled periodically.
        for (int i = 0; i < 4; i++) begin
            repeat (50) @(posedge clk_in);
            #1;
            chk($sformatf("rst_c_%0d", i), {2'b0, c}, 8'd0);
            chk($sformatf("rst_gnd_%0d", i), {7'b0, c_gnd}, 8'd1);
            chk($sformatf("rst_ss_%0d", i), {7'b0, sample_switch}, 8'd0);
            chk($sformatf("rst_n_%0d", i), {3'b0, n}, 8'd0);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        run_conv("reject", 0, 23);

        mode = 1;
        do_reset(3);
        run_conv("accept", 31, 23);

        mode  = 2;
        vin10 = 128;
        do_reset(3);
        run_conv("vin12p8", 12, 12);

        mode = 3;
        do_reset(3);
        run_conv("invalid", 0, 12);

        mode = 2;
        for (int r = 0; r < 6; r++) begin
            vin10 = $urandom_range(0, 349);
            nexp  = (vin10 / 10 > 31) ? 31 : vin10 / 10;
            do_reset(3);
            run_conv($sformatf("rnd%0d", r), nexp, 12);
        end

        // Reset during TRIAL k=2 of the second conversion discards it and clears n.
        mode = 1;
        do_reset(3);
        run_conv("midrst", 31, 19);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("midrst_c", {2'b0, c}, 8'd0);
        chk("midrst_gnd", {7'b0, c_gnd}, 8'd1);
        chk("midrst_ss", {7'b0, sample_switch}, 8'd0);
        chk("midrst_n", {3'b0, n}, 8'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        run_conv("restart", 31, 12);

        for (int i = 0; i < 30; i++) begin
            @(posedge clk_in);
            #1;
            ct[i] = clock_test;
        end
        highs = 0;
        diffs = 0;
        rises = 0;
        for (int i = 0; i < 10; i++) highs += int'(ct[i]);
        for (int i = 0; i < 20; i++) if (ct[i] !== ct[i + 10]) diffs++;
        for (int i = 1; i < 30; i++) if (!ct[i - 1] && ct[i]) rises++;
`ifdef CLOCK_TEST_EN
        chk("ctest_high", 8'(highs), 8'd5);
        chk("ctest_period", 8'(diffs), 8'd0);
        chk("ctest_rises", 8'(rises), 8'd3);
`else
        chk("ctest_high", 8'(highs), 8'd0);
        chk("ctest_rises", 8'(rises), 8'd0);
`endif
        rs = 10'(diffs);
        chk("ctest_stable", {7'b0, ^rs === 1'bx}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
